// File: rtl/bus_arbiter_pkg.sv
// rtl/bus_arbiter_pkg.sv - shared bus arbiter types, state encodings and defaults
package bus_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY0 = 2'd1,
        BUSY1 = 2'd2
    } arb_state_t;

    localparam int DEFAULT_TIMEOUT_CYCLES = 64;

    // Counter must represent 0..n inclusive so it never wraps at the limit.
    function automatic int wait_cnt_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/arb_timeout_cnt.sv
// rtl/arb_timeout_cnt.sv - bus wait counter with terminal-count flag
module arb_timeout_cnt
    import bus_arbiter_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clear,
    input  logic i_inc,
    output logic o_tc
);

    localparam int CW = wait_cnt_width(TIMEOUT_CYCLES);

    logic [CW-1:0] r_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_inc) begin
            r_count <= r_count + CW'(1);
        end
    end

    // Flags the wait cycle whose increment makes the count reach the limit.
    assign o_tc = i_inc && (r_count == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - two-master round-robin arbiter for a shared bus with timeout abort
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m0_req,
    input  logic        m0_wr,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic        m0_ready,
    output logic        m0_err,
    output logic [31:0] m0_rdata,
    input  logic        m1_req,
    input  logic        m1_wr,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic        m1_ready,
    output logic        m1_err,
    output logic [31:0] m1_rdata,
    output logic        bus_req,
    output logic        bus_wr,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ready,
    output logic        cpu_stall
);

    arb_state_t  r_state;
    arb_state_t  w_next_state;
    logic        r_last_m1;
    logic        r_bus_wr;
    logic [31:0] r_bus_addr;
    logic [31:0] r_bus_wdata;
    logic        r_m0_ready, r_m0_err, r_m1_ready, r_m1_err;
    logic [31:0] r_m0_rdata, r_m1_rdata;

    logic w_elig0, w_elig1;
    logic w_grant, w_grant_m1;
    logic w_done, w_abort;
    logic w_busy, w_cur_m1;
    logic w_tc;

    // A master is not re-eligible in the cycle its completion pulse is out.
    assign w_elig0  = m0_req && !r_m0_ready;
    assign w_elig1  = m1_req && !r_m1_ready;
    assign w_busy   = (r_state != IDLE);
    assign w_cur_m1 = (r_state == BUSY1);

    arb_timeout_cnt #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout_cnt (
        .clk    (clk),
        .reset  (reset),
        .i_clear(w_grant),
        .i_inc  (w_busy && !bus_ready),
        .o_tc   (w_tc)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_grant      = 1'b0;
        w_grant_m1   = 1'b0;
        w_done       = 1'b0;
        w_abort      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_elig0 && w_elig1) begin
                    w_grant    = 1'b1;
                    w_grant_m1 = !r_last_m1;
                end else if (w_elig0 || w_elig1) begin
                    w_grant    = 1'b1;
                    w_grant_m1 = w_elig1;
                end
                if (w_grant) begin
                    w_next_state = w_grant_m1 ? BUSY1 : BUSY0;
                end
            end
            BUSY0, BUSY1: begin
                if (bus_ready) begin
                    w_done       = 1'b1;
                    w_next_state = IDLE;
                end else if (w_tc) begin
                    w_abort      = 1'b1;
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_last_m1   <= 1'b1;
            r_bus_wr    <= 1'b0;
            r_bus_addr  <= '0;
            r_bus_wdata <= '0;
            r_m0_ready  <= 1'b0;
            r_m0_err    <= 1'b0;
            r_m1_ready  <= 1'b0;
            r_m1_err    <= 1'b0;
            r_m0_rdata  <= '0;
            r_m1_rdata  <= '0;
        end else begin
            r_m0_ready <= 1'b0;
            r_m0_err   <= 1'b0;
            r_m1_ready <= 1'b0;
            r_m1_err   <= 1'b0;
            if (w_grant) begin
                r_bus_wr    <= w_grant_m1 ? m1_wr    : m0_wr;
                r_bus_addr  <= w_grant_m1 ? m1_addr  : m0_addr;
                r_bus_wdata <= w_grant_m1 ? m1_wdata : m0_wdata;
            end
            if (w_done) begin
                r_last_m1 <= w_cur_m1;
                if (w_cur_m1) begin
                    r_m1_ready <= 1'b1;
                    if (!r_bus_wr) r_m1_rdata <= bus_rdata;
                end else begin
                    r_m0_ready <= 1'b1;
                    if (!r_bus_wr) r_m0_rdata <= bus_rdata;
                end
            end
            if (w_abort) begin
                r_last_m1 <= w_cur_m1;
                if (w_cur_m1) begin
                    r_m1_ready <= 1'b1;
                    r_m1_err   <= 1'b1;
                    r_m1_rdata <= '0;
                end else begin
                    r_m0_ready <= 1'b1;
                    r_m0_err   <= 1'b1;
                    r_m0_rdata <= '0;
                end
            end
        end
    end

    assign bus_req   = w_busy;
    assign bus_wr    = r_bus_wr;
    assign bus_addr  = r_bus_addr;
    assign bus_wdata = r_bus_wdata;
    assign m0_ready  = r_m0_ready;
    assign m0_err    = r_m0_err;
    assign m0_rdata  = r_m0_rdata;
    assign m1_ready  = r_m1_ready;
    assign m1_err    = r_m1_err;
    assign m1_rdata  = r_m1_rdata;
    assign cpu_stall = m0_req && !r_m0_ready;

endmodule
